// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and
// counter-width helper, common to the transmit and receive sides.
package uart_pkg;

  localparam int DEFAULT_FRAME_WIDTH  = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Width needed to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_baud_counter.sv
// Bit-period timer: cnt_done marks the last clk cycle of each serial bit.
// With cnt_en low at that point the timer stops; otherwise it rolls into the next bit.
module tx_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_load,
  input  logic cnt_en,
  output logic cnt_done,
  output logic cnt_busy
);

  localparam int unsigned W = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;

  assign cnt_done = busy_q && (cnt_q == LAST);
  assign cnt_busy = busy_q;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (cnt_load) begin
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (cnt_done) begin
      cnt_d  = '0;
      busy_d = cnt_en;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// All outputs are registered; done pulses in the idle cycle after the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_en,
  input  logic                   tx_start,
  input  logic [FRAME_WIDTH-1:0] data,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned BW = $clog2(FRAME_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_WIDTH);

  uart_state_e            state_q, state_d;
  logic [FRAME_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]          bitcnt_q, bitcnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   par_q, par_d;

  logic cnt_load, cnt_en, cnt_done, cnt_busy;
  logic accept, adv;

  tx_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .cnt_load (cnt_load),
    .cnt_en   (cnt_en),
    .cnt_done (cnt_done),
    .cnt_busy (cnt_busy)
  );

  assign accept = tx_en && tx_start && !busy_q;
  assign adv    = cnt_busy && cnt_done;

  // bitcnt holds the number of data bits already placed on the line.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    par_d    = par_q;
    cnt_load = 1'b0;
    cnt_en   = (state_q != STOP);

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d  = START;
          shreg_d  = data;
          par_d    = (^data) ^ (PARITY_ODD != 0);
          bitcnt_d = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end
      START: begin
        if (adv) begin
          state_d  = DATA;
          tx_d     = shreg_q[0];
          shreg_d  = shreg_q >> 1;
          bitcnt_d = BW'(1);
        end
      end
      DATA: begin
        if (adv) begin
          if (bitcnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d     = shreg_q[0];
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (adv) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (adv) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      par_q    <= par_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameters SHALL be:
- FRAME_WIDTH, default 8: data bits per frame.
- CLKS_PER_BIT, default 868: clk cycles per serial bit, minimum 2.
- PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, default 0: 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.

REQ-002 Ports SHALL be:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_en  input  1  transmitter enable; gates acceptance of new frames.
- tx_start  input  1  request to send data; sampled when busy=0.
- data  input  FRAME_WIDTH  payload, captured on the accepting edge.
- tx  output  1  serial line; idles high; registered.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse at frame completion.

Function
REQ-003 A frame SHALL be accepted on a rising edge where tx_en=1, tx_start=1 and busy=0; data SHALL be captured into an internal shift register on that same edge.
REQ-004 tx_start SHALL be ignored while busy=1 or tx_en=0; no queuing.
REQ-005 Frame format SHALL be: start bit (0), FRAME_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
REQ-006 Each bit SHALL be driven on tx for exactly CLKS_PER_BIT cycles; total frame time SHALL be (2+FRAME_WIDTH+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-007 tx SHALL go low, and busy high, in the cycle immediately following the accepting edge (latency 1 cycle).
REQ-008 Parity SHALL be the XOR of the captured data bits, inverted when PARITY_ODD=1.
REQ-009 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, with these transitions:
- IDLE->START on accept.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->PARITY, or DATA->STOP when PARITY_EN=0, after FRAME_WIDTH bit periods.
- PARITY->STOP after one bit period.
- STOP->IDLE after one bit period.
REQ-010 done SHALL pulse high for exactly one cycle, namely the first cycle after the final stop-bit cycle; busy SHALL be 0 in that cycle.
REQ-011 A tx_start presented in the done cycle SHALL be accepted, giving back-to-back frames with no idle gap beyond the full stop bit.
REQ-012 Deasserting tx_en mid-frame SHALL NOT abort the frame; the frame completes normally and no new frame is accepted.
REQ-013 The bit counter SHALL be ceil(log2(FRAME_WIDTH+1)) wide and the baud counter ceil(log2(CLKS_PER_BIT)) wide; neither counter SHALL wrap within a frame.
REQ-014 Changes to data after the accepting edge SHALL NOT affect the frame in flight.

Reset
REQ-015 On rst=0, asynchronously: tx=1, busy=0, done=0, FSM=IDLE, all counters and the shift register =0.
REQ-016 Reset asserted mid-frame SHALL abort the frame immediately, return tx high and produce no done pulse.
REQ-017 After reset release, the first accept SHALL be possible on the first rising edge with rst=1.

Structure
REQ-018 A shared package uart_pkg SHALL hold the FSM state enum and the default FRAME_WIDTH and CLKS_PER_BIT constants, for use by both the transmit and receive sides.
REQ-019 Bit timing SHALL be in a sub-module tx_baud_counter with ports cnt_load, cnt_en, cnt_done, cnt_busy, clk, rst; the FSM and shift register SHALL reside in uart_tx.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-020 Send data=8'hA5, PARITY_EN=0 -> tx samples mid-bit read 0,1,0,1,0,0,1,0,1,1; busy high for 40 cycles; done pulse at cycle 41.
REQ-021 PARITY_EN=1, PARITY_ODD=0, data=8'h07 -> parity bit =1; frame length 44 cycles.
REQ-022 Second tx_start pulse 10 cycles into frame with data=8'hFF -> ignored; first frame unchanged; one done pulse only.
REQ-023 Two frames 8'h00 then 8'hFF, second tx_start in the done cycle -> stop bit exactly 4 cycles, then start bit immediately.
REQ-024 rst=0 asserted 15 cycles into a frame -> tx=1 and busy=0 within the same cycle; no done; next frame after release is correct.
REQ-025 tx_en dropped 5 cycles into a frame -> frame completes with done; a tx_start after done with tx_en=0 -> no frame sent.
